ps2_device: RTL and testbench

- PS/2 device-side endpoint: the keyboard/mouse end of the link that the host-side PS/2 core talks to.
- Generates the PS/2 clock and sends device-to-host frames (scan codes, replies).
- Detects host inhibit and host request-to-send, then clocks in host-to-device command bytes and acknowledges them.
- Used as an on-chip loopback partner for the host core and as a keyboard emulator on a PMOD PS/2 port.

---
 rtl/ps2_dev_pkg.sv | 28 ++
 rtl/ps2_dev_sync.sv | 30 +++
 rtl/ps2_device.sv | 318 +++++++++++++++++++++++++++++++
 tb/tb_ps2_device.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_dev_pkg.sv
// Shared types and constants for the PS/2 device-side endpoint.
package ps2_dev_pkg;

  typedef enum logic [3:0] {
    IDLE,
    INHIBIT,
    TX_HI,
    TX_LO,
    RX_LO,
    RX_HI,
    ACK_LO,
    ACK_HI,
    GAP
  } state_t;

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned RX_BITS     = 10;
  localparam logic [7:0]  PS2_RESEND  = 8'hFE;
  localparam int unsigned BIT_IDX_W   = 4;
  // Cycles after releasing ps2c before the synchronised level can be trusted
  localparam int unsigned SYNC_SETTLE = 3;

  // Parity bit that makes data plus parity contain an odd number of ones
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_dev_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines (idle level high).
module ps2_dev_sync
  import ps2_dev_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_s_o,
  output logic ps2d_s_o
);

  logic [1:0] c_q;
  logic [1:0] d_q;

  // Shift each line through two flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q <= 2'b11;
      d_q <= 2'b11;
    end else begin
      c_q <= {c_q[0], ps2c_i};
      d_q <= {d_q[0], ps2d_i};
    end
  end

  assign ps2c_s_o = c_q[1];
  assign ps2d_s_o = d_q[1];

endmodule

// File: rtl/ps2_device.sv
// PS/2 device-side endpoint: generates the PS/2 clock, sends device-to-host
// frames, and receives/acknowledges host-to-device command bytes.
// Optional: define PS2_DEV_AUTO_RESEND_EN to answer a receive parity error
// with an automatic Resend (8'hFE) frame instead of pulsing rx_err.
module ps2_device
  import ps2_dev_pkg::*;
#(
  parameter int unsigned CLK_HALF = 4000,
  parameter int unsigned GAP_CYC  = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] ps2_tx_data,
  output logic       ps2_tx_idle,
  output logic       tx_done_tick,
  output logic [7:0] ps2_rx_data,
  output logic       rx_done_tick,
  output logic       rx_err,
  inout  wire        ps2d,
  inout  wire        ps2c
);

  localparam int unsigned CNT_MAX = (GAP_CYC > CLK_HALF) ? GAP_CYC : CLK_HALF;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]     HALF_END = CNT_W'(CLK_HALF - 1);
  localparam logic [CNT_W-1:0]     HALF_MID = CNT_W'(CLK_HALF / 2);
  localparam logic [CNT_W-1:0]     GAP_END  = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0]     SETTLE   = CNT_W'(SYNC_SETTLE);
  localparam logic [BIT_IDX_W-1:0] TX_LAST  = BIT_IDX_W'(FRAME_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] RX_LAST  = BIT_IDX_W'(RX_BITS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic                   c_drv_q, c_drv_d;
  logic                   d_drv_q, d_drv_d;
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   resend_q, resend_d;
  logic                   tx_sel_q, tx_sel_d;
  logic                   done_pend_q, done_pend_d;
  logic [RX_BITS-1:0]     rx_bits_q, rx_bits_d;
  logic                   stop_err_q, stop_err_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   tx_done_q, tx_done_d;
  logic                   rx_done_q, rx_done_d;
  logic                   rx_err_q, rx_err_d;
  logic                   idle_q, idle_d;

  logic                   c_s;
  logic                   d_s;
  logic                   host_low_c;
  logic [7:0]             tx_byte_c;
  logic [FRAME_BITS-1:0]  tx_frame_c;
  logic                   tx_bit_c;

  ps2_dev_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .ps2c_i   (ps2c),
    .ps2d_i   (ps2d),
    .ps2c_s_o (c_s),
    .ps2d_s_o (d_s)
  );

  // Open-drain line drivers
  assign ps2c = c_drv_q ? 1'b0 : 1'bz;
  assign ps2d = d_drv_q ? 1'b0 : 1'bz;

  // Frame bits for the byte currently being sent (resend slot has priority)
  assign host_low_c = ~c_s & ~c_drv_q;
  assign tx_byte_c  = tx_sel_q ? PS2_RESEND : hold_q;
  assign tx_frame_c = {1'b1, odd_parity(tx_byte_c), tx_byte_c, 1'b0};
  assign tx_bit_c   = tx_frame_c[bit_q];

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      c_drv_q     <= 1'b0;
      d_drv_q     <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      resend_q    <= 1'b0;
      tx_sel_q    <= 1'b0;
      done_pend_q <= 1'b0;
      rx_bits_q   <= '0;
      stop_err_q  <= 1'b0;
      rx_data_q   <= '0;
      tx_done_q   <= 1'b0;
      rx_done_q   <= 1'b0;
      rx_err_q    <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      c_drv_q     <= c_drv_d;
      d_drv_q     <= d_drv_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      resend_q    <= resend_d;
      tx_sel_q    <= tx_sel_d;
      done_pend_q <= done_pend_d;
      rx_bits_q   <= rx_bits_d;
      stop_err_q  <= stop_err_d;
      rx_data_q   <= rx_data_d;
      tx_done_q   <= tx_done_d;
      rx_done_q   <= rx_done_d;
      rx_err_q    <= rx_err_d;
      idle_q      <= idle_d;
    end
  end

  // Next-state, line control and holding-register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    c_drv_d     = c_drv_q;
    d_drv_d     = d_drv_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    resend_d    = resend_q;
    tx_sel_d    = tx_sel_q;
    done_pend_d = done_pend_q;
    rx_bits_d   = rx_bits_q;
    stop_err_d  = stop_err_q;
    rx_data_d   = rx_data_q;
    tx_done_d   = 1'b0;
    rx_done_d   = 1'b0;
    rx_err_d    = 1'b0;

    if (wr_ps2 && idle_q) begin
      hold_d      = ps2_tx_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (host_low_c) begin
          state_d = INHIBIT;
          cnt_d   = '0;
        end else begin
          if (!c_s) begin
            cnt_d = '0;
          end else if (cnt_q != GAP_END) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if ((hold_full_q || resend_q) && c_s && (cnt_q == GAP_END)) begin
            state_d  = TX_HI;
            cnt_d    = '0;
            bit_d    = '0;
            tx_sel_d = resend_q;
          end
        end
      end

      INHIBIT: begin
        if (c_s) begin
          cnt_d = '0;
          if (!d_s) begin
            state_d    = RX_LO;
            c_drv_d    = 1'b1;
            bit_d      = '0;
            stop_err_d = 1'b0;
          end else begin
            state_d = GAP;
          end
        end
      end

      TX_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_MID) begin
          d_drv_d = ~tx_bit_c;
        end
        // The first few cycles are masked: ps2c was just released and the
        // synchronised level still shows our own low drive.
        if (host_low_c && (cnt_q >= SETTLE) && (bit_q < TX_LAST)) begin
          c_drv_d = 1'b0;
          d_drv_d = 1'b0;
          state_d = INHIBIT;
          cnt_d   = '0;
        end else if (cnt_q == HALF_END) begin
          state_d = TX_LO;
          c_drv_d = 1'b1;
          cnt_d   = '0;
        end
      end

      TX_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_END) begin
          cnt_d   = '0;
          bit_d   = bit_q + BIT_IDX_W'(1);
          c_drv_d = 1'b0;
          if (bit_q == TX_LAST) begin
            d_drv_d     = 1'b0;
            state_d     = GAP;
            done_pend_d = 1'b1;
          end else begin
            state_d = TX_HI;
          end
        end
      end

      GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_END) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (done_pend_q) begin
            done_pend_d = 1'b0;
            if (tx_sel_q) begin
              resend_d = 1'b0;
            end else begin
              hold_full_d = 1'b0;
              tx_done_d   = 1'b1;
            end
          end
        end
      end

      RX_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_END) begin
          state_d = RX_HI;
          c_drv_d = 1'b0;
          cnt_d   = '0;
        end
      end

      RX_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_MID) begin
          rx_bits_d[bit_q] = d_s;
        end
        if (cnt_q == HALF_END) begin
          cnt_d = '0;
          if (bit_q != RX_LAST) begin
            bit_d   = bit_q + BIT_IDX_W'(1);
            state_d = RX_LO;
            c_drv_d = 1'b1;
          end else if (rx_bits_q[RX_BITS-1]) begin
            if (stop_err_q) begin
              state_d    = GAP;
              stop_err_d = 1'b0;
            end else begin
              state_d = ACK_LO;
              c_drv_d = 1'b1;
              d_drv_d = 1'b1;
            end
          end else begin
            // Bad stop bit: flag once, keep clocking until the host lets go
            if (!stop_err_q) begin
              rx_err_d = 1'b1;
            end
            stop_err_d = 1'b1;
            state_d    = RX_LO;
            c_drv_d    = 1'b1;
          end
        end
      end

      ACK_LO: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_END) begin
          state_d = ACK_HI;
          c_drv_d = 1'b0;
          cnt_d   = '0;
        end
      end

      ACK_HI: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == HALF_MID) begin
          d_drv_d = 1'b0;
        end
        if (cnt_q == HALF_END) begin
          state_d = GAP;
          cnt_d   = '0;
          d_drv_d = 1'b0;
          if (rx_bits_q[8] == odd_parity(rx_bits_q[7:0])) begin
            rx_done_d = 1'b1;
            rx_data_d = rx_bits_q[7:0];
          end else begin
`ifdef PS2_DEV_AUTO_RESEND_EN
            resend_d = 1'b1;
`else
            rx_err_d = 1'b1;
`endif
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        c_drv_d = 1'b0;
        d_drv_d = 1'b0;
      end
    endcase

    idle_d = ~hold_full_d & ~resend_d;
  end

  assign ps2_tx_idle  = idle_q;
  assign tx_done_tick = tx_done_q;
  assign ps2_rx_data  = rx_data_q;
  assign rx_done_tick = rx_done_q;
  assign rx_err       = rx_err_q;

endmodule

// File: tb/tb_ps2_device.sv
// Bench for ps2_device: the bench is the PS/2 host. Expected device events are
// queued as stimulus is issued; a monitor decodes device frames and ticks and
// checks them against the queue in order.
`timescale 1ns/1ps
module tb_ps2_device;

  localparam int unsigned CLK_HALF = 8;
  localparam int unsigned GAP_CYC  = 20;

  // Event codes: {kind, data}
  localparam logic [7:0] EV_FRAME  = 8'h01;
  localparam logic [7:0] EV_TXDONE = 8'h02;
  localparam logic [7:0] EV_RXDONE = 8'h03;
  localparam logic [7:0] EV_RXERR  = 8'h04;

  logic       clk;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] ps2_tx_data;
  logic       ps2_tx_idle;
  logic       tx_done_tick;
  logic [7:0] ps2_rx_data;
  logic       rx_done_tick;
  logic       rx_err;
  wire        ps2c;
  wire        ps2d;

  logic host_c_low;
  logic host_d_low;
  logic host_busy;

  int checks;
  int errors;
  int fall_cnt;
  logic [15:0] exp_q[$];

  pullup pu_c (ps2c);
  pullup pu_d (ps2d);
  assign ps2c = host_c_low ? 1'b0 : 1'bz;
  assign ps2d = host_d_low ? 1'b0 : 1'bz;

  ps2_device #(.CLK_HALF(CLK_HALF), .GAP_CYC(GAP_CYC)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .ps2_tx_data  (ps2_tx_data),
    .ps2_tx_idle  (ps2_tx_idle),
    .tx_done_tick (tx_done_tick),
    .ps2_rx_data  (ps2_rx_data),
    .rx_done_tick (rx_done_tick),
    .rx_err       (rx_err),
    .ps2d         (ps2d),
    .ps2c         (ps2c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_observe(input logic [15:0] ev);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected actual=%h required=none", ev);
    end else begin
      e = exp_q.pop_front();
      if (e !== ev) begin
        errors++;
        $display("FAIL sb_event actual=%h required=%h", ev, e);
      end
    end
  endtask

  task automatic wait_fall(input string name);
    logic p;
    bit   ok;
    ok = 1'b0;
    p  = ps2c;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (p === 1'b1 && ps2c === 1'b0) begin
        ok = 1'b1;
        break;
      end
      p = ps2c;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=ps2c_fall", name);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (ps2_tx_idle !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(ps2_tx_idle), 32'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic dev_write(input logic [7:0] b);
    @(negedge clk);
    wr_ps2      = 1'b1;
    ps2_tx_data = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Host-to-device byte: inhibit, request-to-send, then shift bits on falls
  task automatic host_send(input logic [7:0] b, input logic par);
    logic [9:0] bits;
    bits      = {1'b1, par, b};
    host_busy = 1'b1;
    @(negedge clk);
    host_c_low = 1'b1;
    repeat (30) @(negedge clk);
    host_d_low = 1'b1;
    repeat (2) @(negedge clk);
    host_c_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_fall("rx_clk_fall");
      host_d_low = ~bits[i];
    end
    wait_fall("ack_fall");
    repeat (3) @(negedge clk);
    check("ack_d_low", 32'(ps2d), 32'd0);
    check("ack_c_low", 32'(ps2c), 32'd0);
    for (int n = 0; n < 100 && ps2c !== 1'b1; n++) @(negedge clk);
    host_busy = 1'b0;
  endtask

  // Monitor: device ticks and device-to-host frames, sampled on negedge
  initial begin : monitor
    logic        cp;
    int          nb;
    int          hi_run;
    logic [10:0] fr;
    cp     = 1'b1;
    nb     = 0;
    hi_run = 0;
    fr     = '0;
    forever begin
      @(negedge clk);
      if (tx_done_tick === 1'b1) sb_observe({EV_TXDONE, 8'h00});
      if (rx_done_tick === 1'b1) sb_observe({EV_RXDONE, ps2_rx_data});
      if (rx_err === 1'b1)       sb_observe({EV_RXERR, 8'h00});
      if (ps2c === 1'b1) hi_run++;
      else               hi_run = 0;
      if (host_busy || hi_run > 2 * CLK_HALF) begin
        nb = 0;
      end else if (cp === 1'b1 && ps2c === 1'b0 && !host_c_low) begin
        fall_cnt++;
        fr[nb] = ps2d;
        nb++;
        if (nb == 11) begin
          nb = 0;
          sb_observe({EV_FRAME, fr[8:1]});
          // start=0, stop=1, data+parity odd
          check("frame_format", {29'd0, fr[0], fr[10], ^fr[9:1]}, 32'b011);
        end
      end
      cp = ps2c;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int fc0;
    checks      = 0;
    errors      = 0;
    fall_cnt    = 0;
    reset       = 1'b0;
    wr_ps2      = 1'b0;
    ps2_tx_data = 8'h00;
    host_c_low  = 1'b0;
    host_d_low  = 1'b0;
    host_busy   = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_idle", 32'(ps2_tx_idle), 32'd1);
    check("rst_ticks", {29'd0, tx_done_tick, rx_done_tick, rx_err}, 32'd0);
    check("rst_rx_data", 32'(ps2_rx_data), 32'd0);
    check("rst_lines", {30'd0, ps2c, ps2d}, 32'b11);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // 8'h1C: bits 0,0,1,1,1,0,0,0, parity 0
    exp_q.push_back({EV_FRAME, 8'h1C});
    exp_q.push_back({EV_TXDONE, 8'h00});
    dev_write(8'h1C);
    check("busy_after_wr", 32'(ps2_tx_idle), 32'd0);
    wait_idle("idle_after_1c");
    drain("drain_1c");

    // 8'h00: parity 1
    exp_q.push_back({EV_FRAME, 8'h00});
    exp_q.push_back({EV_TXDONE, 8'h00});
    dev_write(8'h00);
    wait_idle("idle_after_00");
    drain("drain_00");

    // 8'hF0 aborted after 4th fall, then retransmitted; a write while busy is dropped
    exp_q.push_back({EV_FRAME, 8'hF0});
    exp_q.push_back({EV_TXDONE, 8'h00});
    dev_write(8'hF0);
    dev_write(8'hAA);
    for (int i = 0; i < 4; i++) wait_fall("f0_fall");
    @(negedge clk);
    host_c_low = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_d_released", 32'(ps2d), 32'd1);
    check("abort_still_held", 32'(ps2_tx_idle), 32'd0);
    repeat (70) @(negedge clk);
    host_c_low = 1'b0;
    wait_idle("idle_after_f0");
    drain("drain_f0");

    // Host sends 8'hED: six ones, so the odd parity bit is 1
    exp_q.push_back({EV_RXDONE, 8'hED});
    host_send(8'hED, 1'b1);
    drain("drain_rx_ed");
    check("rx_data_ed", 32'(ps2_rx_data), 32'hED);

    // Host sends 8'h5A (four ones) with parity 0, which is wrong
`ifdef PS2_DEV_AUTO_RESEND_EN
    exp_q.push_back({EV_FRAME, 8'hFE});
`else
    exp_q.push_back({EV_RXERR, 8'h00});
`endif
    host_send(8'h5A, 1'b0);
    drain("drain_rx_bad");
    wait_idle("idle_after_bad");
    check("rx_data_kept", 32'(ps2_rx_data), 32'hED);

    // Reset mid-frame (3rd fall: device driving ps2c low and ps2d low for bit1 of 8'h55)
    dev_write(8'h55);
    for (int i = 0; i < 3; i++) wait_fall("rst_tx_fall");
    reset = 1'b0;
    #1;
    check("rst_mid_lines", {30'd0, ps2c, ps2d}, 32'b11);
    check("rst_mid_idle", 32'(ps2_tx_idle), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    fc0 = fall_cnt;
    repeat (200) @(negedge clk);
    check("rst_no_frame", 32'(fall_cnt - fc0), 32'd0);
    check("rst_idle_after", 32'(ps2_tx_idle), 32'd1);
    drain("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
